// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial pattern detector.
// A pattern of 1..MAX_LEN bits, its length and an overlap mode are latched by
// a load strobe. Each enabled clock edge shifts one bit of xin into a history
// register, and a match produces a one-cycle registered pulse on out.
// Optional match counter: define SEQ_DET_PROG_CNT_EN to build a saturating
// match_cnt. Without it, match_cnt is tied to zero.
//
// Handshake: there is no backpressure. xin is consumed on every rising edge
// where en=1 and load=0. out is valid for the single cycle that follows the
// edge that consumed the final pattern bit.
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               xin,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic               ovl,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    // Latched configuration. A length of zero means detection is disabled.
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    // Received-bit history (newest bit in bit 0) and count of valid bits in it.
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   vcnt_q, vcnt_d;

    // Registered match pulse.
    logic               out_q, out_d;

    // Combinational helpers for the current edge.
    logic               len_ok;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   vcnt_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    // Compare the history as it will be after this edge against the pattern.
    always_comb begin
        len_ok     = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
        hist_shift = {hist_q[MAX_LEN-2:0], xin};
        vcnt_inc   = (vcnt_q == LEN_W'(MAX_LEN)) ? vcnt_q : vcnt_q + 1'b1;
        len_mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        match = en && !load && len_ok && (vcnt_inc >= len_q) &&
                ((hist_shift & len_mask) == (pat_q & len_mask));
    end

    // Next-state for configuration, history, valid count and out pulse.
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        out_d  = 1'b0;
        if (load) begin
            // Loading restarts detection from scratch; this edge's xin is dropped.
            pat_d  = pat;
            len_d  = len;
            ovl_d  = ovl;
            hist_d = '0;
            vcnt_d = '0;
        end else if (en) begin
            hist_d = hist_shift;
            // Non-overlapping mode forgets the matched bits so the next match
            // needs a full set of fresh bits.
            vcnt_d = (match && !ovl_q) ? '0 : vcnt_inc;
            out_d  = match;
        end
    end

    // State registers with asynchronous reset to the disabled configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            hist_q <= '0;
            vcnt_q <= '0;
            out_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

`ifdef SEQ_DET_PROG_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of match pulses, cleared by load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
